// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, ALU codes,
// FSM states, halt causes and small decode helpers.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [1:0] HC_NONE        = 2'b00;
    localparam logic [1:0] HC_ILLEGAL     = 2'b01;
    localparam logic [1:0] HC_DATA_ALIGN  = 2'b10;
    localparam logic [1:0] HC_FETCH_ALIGN = 2'b11;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:   imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [3:0] alu_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        if (op == OP_BRANCH) begin
            ctrl = ALU_SUB;
        end else if (op == OP_R || op == OP_I) begin
            case (f3)
                F3_ADD:  ctrl = (op == OP_R && f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                F3_OR:   ctrl = ALU_OR;
                F3_AND:  ctrl = ALU_AND;
                default: ctrl = ALU_ADD;
            endcase
        end
        return ctrl;
    endfunction

    function automatic logic [31:0] alu_op(input logic [3:0] ctrl, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] y;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32 x 32-bit register file: two asynchronous reads, one synchronous write, x0 reads zero.
module rv_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic        i_we,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && i_rd != 5'd0) begin
            r_regs[i_rd] <= i_wdata;
        end
    end

    assign o_rs1_data = (i_rs1 == 5'd0) ? 32'd0 : r_regs[i_rs1];
    assign o_rs2_data = (i_rs2 == 5'd0) ? 32'd0 : r_regs[i_rs2];

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core with req/ack instruction and data ports.
// state  | meaning
// FETCH  | imem_req held until imem_ack, IR captured
// DECODE | operands, immediate latched; opcode classified
// EXEC   | ALU; branch/jal resolve; alignment checks
// MEM    | dmem_req held until dmem_ack
// WB     | register write, retire
// HALT   | terminal fault state until reset
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              retire,
    output logic [31:0]       pc_out,
    output logic              halted,
    output logic [1:0]        halt_cause
);

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu_out, r_mdr, r_dmem_addr, r_dmem_wdata;
    logic        r_imem_req, r_dmem_req, r_dmem_we, r_retire, r_halted;
    logic [1:0]  r_halt_cause;

    logic [6:0]  w_op;
    logic [31:0] w_rs1_data, w_rs2_data, w_alu_b, w_alu, w_pc_plus4, w_next_pc, w_rf_wdata;
    logic        w_is_jal, w_taken, w_rf_we;

    assign w_op = r_ir[6:0];

    always_comb begin
        w_alu_b    = (w_op == OP_R || w_op == OP_BRANCH) ? r_b : r_imm;
        w_alu      = alu_op(alu_ctrl(w_op, r_ir[14:12], r_ir[31:25]), r_a, w_alu_b);
        w_pc_plus4 = r_pc + 32'd4;
        w_is_jal   = (w_op == OP_JAL);
        w_taken    = w_is_jal || (w_op == OP_BRANCH &&
                     ((w_alu == 32'd0) != (r_ir[14:12] == F3_BNE)));
        w_next_pc  = w_taken ? (r_pc + r_imm) : w_pc_plus4;
        // jal links in EXEC, but only if its target is legal
        w_rf_we    = (r_state == WB) ||
                     (r_state == EXEC && w_is_jal && w_next_pc[1:0] == 2'b00);
        w_rf_wdata = (r_state == EXEC) ? w_pc_plus4 : ((w_op == OP_LOAD) ? r_mdr : r_alu_out);
    end

    rv_regfile u_regfile (
        .clk        (clk),
        .reset      (reset),
        .i_rs1      (r_ir[19:15]),
        .i_rs2      (r_ir[24:20]),
        .i_we       (w_rf_we),
        .i_rd       (r_ir[11:7]),
        .i_wdata    (w_rf_wdata),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_alu_out    <= '0;
            r_mdr        <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b0;
            r_halt_cause <= HC_NONE;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    r_a   <= w_rs1_data;
                    r_b   <= w_rs2_data;
                    r_imm <= imm_gen(r_ir);
                    if (!is_legal(w_op)) begin
                        if (HALT_ON_ILLEGAL) begin
                            r_halted     <= 1'b1;
                            r_halt_cause <= HC_ILLEGAL;
                            r_state      <= HALT;
                        end else begin
                            r_retire   <= 1'b1;
                            r_pc       <= w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_alu_out <= w_alu;
                    if (w_op == OP_BRANCH || w_is_jal) begin
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_halted     <= 1'b1;
                            r_halt_cause <= HC_FETCH_ALIGN;
                            r_state      <= HALT;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end else if (w_op == OP_LOAD || w_op == OP_STORE) begin
                        if (w_alu[1:0] != 2'b00) begin
                            r_halted     <= 1'b1;
                            r_halt_cause <= HC_DATA_ALIGN;
                            r_state      <= HALT;
                        end else begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (w_op == OP_STORE);
                            r_dmem_addr  <= w_alu;
                            r_dmem_wdata <= r_b;
                            r_state      <= MEM;
                        end
                    end else begin
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_retire   <= 1'b1;
                            r_pc       <= w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= WB;
                        end
                    end
                end
                WB: begin
                    r_retire   <= 1'b1;
                    r_pc       <= w_pc_plus4;
                    r_imem_req <= 1'b1;
                    r_state    <= FETCH;
                end
                HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc[ADDR_W-1:0];
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr[ADDR_W-1:0];
    assign dmem_wdata = r_dmem_wdata;
    assign retire     = r_retire;
    assign pc_out     = r_pc;
    assign halted     = r_halted;
    assign halt_cause = r_halt_cause;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: small programs against req/ack memory models.
module tb_rv_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, dmem_req, dmem_we, retire, halted;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc_out;
    logic [1:0]  halt_cause;
    logic [31:0] imem_rdata = '0;
    logic [31:0] dmem_rdata = '0;
    logic        m_iack = 1'b0, m_dack = 1'b0, inj_ack = 1'b0;
    logic        imem_ack, dmem_ack;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int          i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
    int          total = 0, bad = 0;

    int          cyc = 0, n_ret = 0, n_dreq = 0, n_both = 0, n_unstable = 0;
    int          ret_cyc [0:255];
    logic        p_dreq = 1'b0, p_dack = 1'b0, p_dwe = 1'b0, p_ireq = 1'b0, p_iack = 1'b0;
    logic [31:0] p_daddr = '0, p_dwdata = '0, p_iaddr = '0;

    always #5 clk = ~clk;

    assign imem_ack = m_iack | inj_ack;
    assign dmem_ack = m_dack;

    rv_multicycle_core #(
        .RESET_PC        (32'h0000_0000),
        .ADDR_W          (32),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .retire     (retire),
        .pc_out     (pc_out),
        .halted     (halted),
        .halt_cause (halt_cause)
    );

    // memory models: ack after i_wait/d_wait extra cycles of a held request
    always @(posedge clk) begin
        m_iack <= 1'b0;
        if (imem_req && !m_iack) begin
            if (i_cnt >= i_wait) begin
                m_iack     <= 1'b1;
                imem_rdata <= imem[imem_addr[9:2]];
                i_cnt      <= 0;
            end else begin
                i_cnt <= i_cnt + 1;
            end
        end else if (!imem_req) begin
            i_cnt <= 0;
        end
        m_dack <= 1'b0;
        if (dmem_req && !m_dack) begin
            if (d_cnt >= d_wait) begin
                m_dack <= 1'b1;
                if (dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
                else         dmem_rdata <= dmem[dmem_addr[9:2]];
                d_cnt <= 0;
            end else begin
                d_cnt <= d_cnt + 1;
            end
        end else if (!dmem_req) begin
            d_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (retire) begin
            if (n_ret < 256) ret_cyc[n_ret] = cyc;
            n_ret++;
        end
        if (dmem_req) n_dreq++;
        if (imem_req && dmem_req) n_both++;
        if (dmem_req && p_dreq && !p_dack &&
            (dmem_addr !== p_daddr || dmem_wdata !== p_dwdata || dmem_we !== p_dwe)) n_unstable++;
        if (imem_req && p_ireq && !p_iack && imem_addr !== p_iaddr) n_unstable++;
        p_dreq = dmem_req; p_dack = dmem_ack; p_daddr = dmem_addr; p_dwdata = dmem_wdata;
        p_dwe = dmem_we; p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    task automatic begin_reset(input int iw, input int dw);
        reset   = 1'b1;
        inj_ack = 1'b0;
        i_wait  = iw;
        d_wait  = dw;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ret(input int n, input string tag);
        int target;
        int k;
        target = n_ret + n;
        k = 0;
        while (n_ret < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val({tag, "_timeout"}, 32'(n_ret >= target), 32'd1);
    endtask

    task automatic wait_halt(input string tag);
        int k;
        k = 0;
        while (!halted && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    initial begin
        int b_ret, b_dreq, b_both, b_unst, c;

        // reset values
        begin_reset(0, 3);
        check_val("rst_imem_req", 32'(imem_req), 32'd0);
        check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_val("rst_dmem_we", 32'(dmem_we), 32'd0);
        check_val("rst_retire", 32'(retire), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_cause", 32'(halt_cause), 32'd0);
        check_val("rst_pc", pc_out, 32'd0);
        check_val("rst_daddr", dmem_addr, 32'd0);
        check_val("rst_dwdata", dmem_wdata, 32'd0);

        // ALU sequence, then store/load with 3 data wait states
        imem[0] = enc_i(5, 0, 3'b000, 1, OPI);
        imem[1] = enc_i(7, 0, 3'b000, 2, OPI);
        imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        imem[3] = enc_r(7'h20, 2, 1, 3'b000, 4);
        imem[4] = enc_s(8, 3, 0);
        imem[5] = enc_i(8, 0, 3'b010, 5, OPL);
        imem[6] = enc_s(12, 5, 0);
        imem[7] = enc_s(16, 4, 0);
        b_both = n_both;
        b_unst = n_unstable;
        release_reset();
        wait_ret(4, "alu");
        check_val("alu_pc", pc_out, 32'h10);
        check_val("alu_gap1", ret_cyc[n_ret-3] - ret_cyc[n_ret-4], 32'd5);
        check_val("alu_gap2", ret_cyc[n_ret-2] - ret_cyc[n_ret-3], 32'd5);
        check_val("alu_gap3", ret_cyc[n_ret-1] - ret_cyc[n_ret-2], 32'd5);
        wait_ret(1, "sw");
        check_val("sw_lat", ret_cyc[n_ret-1] - ret_cyc[n_ret-2], 32'd9);
        check_val("sw_mem", dmem[2], 32'd12);
        wait_ret(1, "lw");
        check_val("lw_lat", ret_cyc[n_ret-1] - ret_cyc[n_ret-2], 32'd10);
        wait_ret(2, "st2");
        check_val("lw_x5", dmem[3], 32'd12);
        check_val("sub_x4", dmem[4], 32'hFFFF_FFFE);
        check_val("st2_pc", pc_out, 32'h20);
        wait_halt("end0");
        check_val("end0_cause", 32'(halt_cause), 32'd1);
        check_val("end0_pc", pc_out, 32'h20);
        check_val("req_stable", 32'(n_unstable - b_unst), 32'd0);
        check_val("req_exclusive", 32'(n_both - b_both), 32'd0);

        // beq taken backwards
        begin_reset(0, 0);
        imem[0] = enc_i(5, 0, 3'b000, 1, OPI);
        imem[1] = enc_j(28, 0);
        imem[8] = enc_b(-8, 1, 1, 3'b000);
        release_reset();
        wait_ret(3, "beq");
        check_val("beq_pc", pc_out, 32'h18);
        check_val("jal_lat", ret_cyc[n_ret-2] - ret_cyc[n_ret-3], 32'd4);
        check_val("beq_lat", ret_cyc[n_ret-1] - ret_cyc[n_ret-2], 32'd4);

        // bne not taken
        begin_reset(0, 0);
        imem[0] = enc_i(5, 0, 3'b000, 1, OPI);
        imem[1] = enc_j(28, 0);
        imem[8] = enc_b(-8, 1, 1, 3'b001);
        release_reset();
        wait_ret(3, "bne");
        check_val("bne_pc", pc_out, 32'h24);

        // jal link value
        begin_reset(0, 0);
        imem[0]  = enc_j(48, 0);
        imem[12] = enc_j(16, 6);
        imem[16] = enc_s(0, 6, 0);
        release_reset();
        wait_ret(2, "jal");
        check_val("jal_pc", pc_out, 32'h40);
        wait_ret(1, "jal_st");
        check_val("jal_link", dmem[0], 32'h34);

        // misaligned load
        begin_reset(0, 0);
        imem[0] = enc_i(2, 0, 3'b010, 7, OPL);
        b_ret  = n_ret;
        b_dreq = n_dreq;
        release_reset();
        wait_halt("mis_ld");
        check_val("mis_ld_cause", 32'(halt_cause), 32'd2);
        check_val("mis_ld_pc", pc_out, 32'h0);
        check_val("mis_ld_noreq", 32'(n_dreq - b_dreq), 32'd0);
        check_val("mis_ld_noret", 32'(n_ret - b_ret), 32'd0);

        // illegal opcode
        begin_reset(0, 0);
        imem[0] = enc_i(1, 0, 3'b000, 1, OPI);
        imem[1] = 32'h0000_007F;
        release_reset();
        wait_halt("ill");
        check_val("ill_cause", 32'(halt_cause), 32'd1);
        check_val("ill_pc", pc_out, 32'h4);

        // x0 stays zero
        begin_reset(0, 0);
        imem[0] = enc_i(-1, 0, 3'b000, 5, OPI);
        imem[1] = enc_s(4, 5, 0);
        imem[2] = enc_i(9, 0, 3'b000, 0, OPI);
        imem[3] = enc_s(4, 0, 0);
        release_reset();
        wait_ret(2, "x0_pre");
        check_val("x0_pre_mem", dmem[1], 32'hFFFF_FFFF);
        wait_ret(1, "x0_addi");
        check_val("x0_addi_pc", pc_out, 32'hC);
        wait_ret(1, "x0_st");
        check_val("x0_zero", dmem[1], 32'h0);

        // misaligned jump target
        begin_reset(0, 0);
        imem[0] = enc_j(2, 0);
        b_ret = n_ret;
        release_reset();
        wait_halt("mis_pc");
        check_val("mis_pc_cause", 32'(halt_cause), 32'd3);
        check_val("mis_pc_pc", pc_out, 32'h0);
        check_val("mis_pc_noret", 32'(n_ret - b_ret), 32'd0);

        // reset during an outstanding fetch; stale acks ignored
        begin_reset(10, 0);
        imem[0] = enc_i(5, 0, 3'b000, 1, OPI);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("rr_req_before", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("rr_req_drop", 32'(imem_req), 32'd0);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        i_wait  = 0;
        @(negedge clk);
        #1;
        reset   = 1'b0;
        inj_ack = 1'b1;
        c       = cyc;
        @(negedge clk);
        #1;
        inj_ack = 1'b0;
        check_val("rr_refetch_req", 32'(imem_req), 32'd1);
        check_val("rr_refetch_addr", imem_addr, 32'h0);
        wait_ret(1, "rr");
        check_val("rr_lat", 32'(ret_cyc[n_ret-1] - c), 32'd6);
        check_val("rr_pc", pc_out, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
